// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// NREQ valid/ready producers. Ownership is granted for bursts of up to
// MAX_BURST beats, and each burst is preceded by one arbitration cycle.
// The owner is stalled while the FIFO is full, and the grant is kept
// during the stall.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 4,
  parameter int MAX_BURST = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               fifo_full,
  output logic               fifo_wr_en,
  output logic [DW-1:0]      fifo_wr_data,
  output logic [NREQ-1:0]    grant_oh,
  output logic               busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 4;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic [CW-1:0]   burst_cnt;

  logic [IW-1:0]   sel;
  logic [NREQ-1:0] sel_oh;
  logic            any_valid;
  logic            xfer;
  logic            release_now;
  logic [IW-1:0]   next_ptr;

  // Pick the first valid requester, scanning from rr_ptr upward with wrap.
  // The scan runs from the farthest index to the nearest one, so the
  // nearest valid requester is written last and wins.
  always_comb begin
    int idx;
    any_valid = 1'b0;
    sel       = rr_ptr;
    idx       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        sel       = IW'(idx);
        any_valid = 1'b1;
      end
    end
    sel_oh      = '0;
    sel_oh[sel] = 1'b1;
  end

  // Drive the write port and ready bits for the owner only. These outputs
  // are gated by rst_n so that a beat presented in a reset cycle is not
  // written.
  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    xfer         = 1'b0;
    if (rst_n && state == BURST) begin
      req_ready[owner] = !fifo_full;
      if (req_valid[owner] && !fifo_full) begin
        xfer         = 1'b1;
        fifo_wr_en   = 1'b1;
        fifo_wr_data = req_data[int'(owner)*DW +: DW];
      end
    end
  end

  // The burst ends on its last permitted beat, or as soon as the owner
  // drops valid (a stall does not prevent this).
  always_comb begin
    release_now = !req_valid[owner] ||
                  (xfer && burst_cnt == CW'(MAX_BURST - 1));
    next_ptr    = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
  end

  // Arbiter state machine with registered grant and busy flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      grant_oh  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            owner     <= sel;
            grant_oh  <= sel_oh;
            burst_cnt <= '0;
            busy      <= 1'b1;
            state     <= BURST;
          end
        end
        BURST: begin
          if (xfer) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
          if (release_now) begin
            state     <= IDLE;
            rr_ptr    <= next_ptr;
            grant_oh  <= '0;
            busy      <= 1'b0;
            burst_cnt <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter in front of the shared 4-bit sync FIFO.
- Shares the single FIFO write port (write enable + 4-bit data) between NREQ independent producers using valid/ready handshakes.
- Grants whole bursts of up to MAX_BURST beats and honours FIFO back-pressure (full).
- Sits between producer logic and the FIFO's write side in the same clock domain.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 4, data width per beat; matches FIFO data width.
- MAX_BURST, 2, maximum beats per grant before forced rotation (1..15).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  NREQ  per-requester beat valid.
- req_data  input  NREQ*DW  requester i data in bits [i*DW +: DW].
- req_ready  output  NREQ  per-requester accept; combinational.
- fifo_full  input  1  FIFO full flag; reflects the current-cycle state.
- fifo_wr_en  output  1  FIFO write enable; combinational.
- fifo_wr_data  output  DW  FIFO write data; combinational mux.
- grant_oh  output  NREQ  registered one-hot of current owner; 0 when idle.
- busy  output  1  registered; 1 in BURST state.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE, rr_ptr=0, owner=0, burst_cnt=0.
  - grant_oh=0, busy=0.
  - req_ready=0, fifo_wr_en=0, fifo_wr_data=0.
  - Reset mid-burst aborts the burst immediately; a beat presented in the reset cycle is not written.
- IDLE:
  - req_ready all 0, fifo_wr_en=0.
  - If any req_valid, select the first valid index scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Next cycle: owner=selected, grant_oh=onehot(owner), burst_cnt=0, state=BURST.
  - Arbitration costs exactly one cycle; no beat transfers in IDLE.
- BURST:
  - req_ready[owner] = !fifo_full; all other ready bits are 0.
  - Transfer when req_valid[owner] && req_ready[owner]. In that cycle fifo_wr_en=1 and fifo_wr_data=req_data[owner], so the FIFO captures on the same edge (zero latency).
  - fifo_wr_data=0 whenever fifo_wr_en=0.
  - Each transfer increments burst_cnt.
  - Release to IDLE on the transfer where burst_cnt==MAX_BURST-1.
  - Release to IDLE on any cycle where req_valid[owner]=0, including while fifo_full=1.
  - On release: rr_ptr=(owner+1) mod NREQ, grant_oh=0, busy=0.
- Back-pressure:
  - fifo_full=1 stalls the owner with grant held.
  - Stalled cycles do not count toward the burst and there is no timeout.
  - Owner valid must stay high with data stable until accepted, or the owner loses its grant.
- Fairness:
  - Worst-case wait for a continuously valid requester is (NREQ-1)*(MAX_BURST+1) cycles plus full-stall cycles.
  - Each burst is one arbitration cycle followed by up to MAX_BURST beats.
- Boundary conditions:
  - The wrap from owner=NREQ-1 sets rr_ptr=0.
  - Non-owner valid changes have no effect during BURST.
  - Simultaneous release and new requests: new requests are evaluated in the following IDLE cycle.
- Invariants:
  - At most one req_ready bit is high.
  - fifo_wr_en is never 1 while fifo_full=1.

Test Plan:
- Reset check: hold rst_n=0 for 2 clocks with all req_valid=1 -> grant_oh=0, busy=0, req_ready=0, fifo_wr_en=0; after release, first grant goes to requester 0.
- Single requester: req 2 valid with data 4'hA then 4'hC -> cycle 1 grant_oh=4'b0100; cycles 2–3 fifo_wr_en=1 with data A then C; cycle 4 IDLE, rr_ptr=3.
- Full contention: all 4 valid continuously, MAX_BURST=2 -> write order 0,0,1,1,2,2,3,3,0,0 with one idle arbitration cycle between bursts (rr_ptr wraps 3→0).
- Back-pressure: req 1 in BURST, fifo_full=1 for 3 cycles then 0 -> req_ready[1]=0 and fifo_wr_en=0 during the stall, grant held, then 2 beats are written and the grant rotates.
- Early release: req 3 granted, drops valid after 1 beat while req 0 is valid -> release, rr_ptr=0, next cycle grant_oh=4'b0001.
- Reset mid-burst: assert rst_n=0 between beats 1 and 2 of a burst -> no second write; all outputs return to reset values on the next edge.
